// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory responder for the core's load/store port.
//
// Accepts one request at a time on a valid/ready request channel, performs a
// byte/halfword/word access on an internal word-organised RAM, and returns
// the result on a valid/ready response channel a fixed LATENCY cycles after
// the accept edge.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid / req_ready        request handshake
//   req_addr, req_we, req_size,  byte address, store flag, size (0 B, 1 H,
//   req_unsigned, req_wdata      2 W, 3 reserved), zero-extend, store data
//   rsp_valid / rsp_ready        response handshake
//   rsp_rdata, rsp_err           extended load data (0 on store/error), fault
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the low address bits are simply truncated.

module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT  = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    localparam logic        LAT_IS_1 = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;

    logic [31:0] mem [DEPTH_WORDS];

    // The access is evaluated on the committing edge. With LATENCY == 1 that
    // is the accept edge itself, so the live request is used instead of the
    // latched copy.
    logic        accept;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_we;
    logic        acc_uns;
    logic [1:0]  acc_size;

    assign accept    = (state == IDLE) && req_valid;
    assign acc_addr  = (state == IDLE) ? req_addr     : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata    : lat_wdata;
    assign acc_we    = (state == IDLE) ? req_we       : lat_we;
    assign acc_uns   = (state == IDLE) ? req_unsigned : lat_uns;
    assign acc_size  = (state == IDLE) ? req_size     : lat_size;

    // Commit happens on the edge that enters RESP; a concurrent reset wins.
    logic commit;
    assign commit = reset_n &&
                    ((accept && LAT_IS_1) || (state == WAIT && cnt == 4'd1));

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and fault.
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          fault;

    assign offset = acc_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (acc_size == 2'd1 && acc_addr[0]) ||
                      (acc_size == 2'd2 && acc_addr[1:0] != 2'b00);
    assign fault = ({1'b0, offset} >= LIMIT) || (acc_size == 2'd3) || misalign;
`else
    assign fault = ({1'b0, offset} >= LIMIT) || (acc_size == 2'd3);
`endif

    // Lane selection and store-data replication / load extraction.
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rd_word;
    logic [31:0] ld_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_word = mem[idx];

    always_comb begin
        be      = 4'b0000;
        wrep    = acc_wdata;
        ld_data = rd_word;
        rd_byte = 8'(rd_word >> {acc_addr[1:0], 3'b000});
        rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_size)
            2'd0: begin
                be      = 4'b0001 << acc_addr[1:0];
                wrep    = {4{acc_wdata[7:0]}};
                ld_data = acc_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            2'd1: begin
                be      = acc_addr[1] ? 4'b1100 : 4'b0011;
                wrep    = {2{acc_wdata[15:0]}};
                ld_data = acc_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            2'd2: begin
                be      = 4'b1111;
                wrep    = acc_wdata;
                ld_data = rd_word;
            end
            default: begin
                be      = 4'b0000;
                ld_data = 32'h0;
            end
        endcase
    end

    logic [31:0] rdata_nxt;
    assign rdata_nxt = (fault || acc_we) ? 32'h0 : ld_data;

    // RAM write port, byte-lane enables.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    // Control FSM with registered handshake/response outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        req_ready <= 1'b0;
                        if (LAT_IS_1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_nxt;
                            rsp_err   <= fault;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_nxt;
                        rsp_err   <= fault;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
